// File: rtl/i2c_config_sequencer_pkg.sv
// i2c_cfg_pkg: shared FSM states, word layout and codec address for the config sequencer
package i2c_cfg_pkg;
    typedef enum logic [3:0] {
        POWER_WAIT, IDLE, LOAD, WAIT_READY, LAUNCH, WAIT_END, GAP, NEXT, DONE, FAIL
    } state_t;
    localparam int WORD_W = 24;
    localparam int DEV_MSB = 23;
    localparam int DEV_LSB = 17;
    localparam int RW_BIT = 16;
    localparam int REG_MSB = 15;
    localparam int REG_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;
    localparam logic [6:0] CODEC_ADDR = 7'h1A;
    function automatic logic [WORD_W-1:0] cfg_word(input logic [7:0] reg_addr, input logic [7:0] data);
        logic [WORD_W-1:0] w;
        w = '0;
        w[DEV_MSB:DEV_LSB] = CODEC_ADDR;
        w[RW_BIT] = 1'b0;
        w[REG_MSB:REG_LSB] = reg_addr;
        w[DATA_MSB:DATA_LSB] = data;
        return w;
    endfunction
endpackage

// File: rtl/i2c_config_sequencer_if.sv
// i2c_config_sequencer_if: sequencer <-> controller/top-level handshake bundle
interface i2c_config_sequencer_if;
    import i2c_cfg_pkg::*;
    logic go;
    logic ready_in;
    logic end_in;
    logic error_in;
    logic [WORD_W-1:0] config_data;
    logic start_bit;
    logic stop_bit;
    logic busy;
    logic done;
    logic fail;
    logic [3:0] word_index;
    modport master (
        input go, ready_in, end_in, error_in,
        output config_data, start_bit, stop_bit, busy, done, fail, word_index
    );
    modport slave (
        output go, ready_in, end_in, error_in,
        input config_data, start_bit, stop_bit, busy, done, fail, word_index
    );
endinterface

// File: rtl/i2c_config_sequencer_rom.sv
// i2c_config_rom: codec configuration table, unused addresses read as zero
module i2c_config_rom
    import i2c_cfg_pkg::*;
(
    input  logic [3:0]        addr,
    output logic [WORD_W-1:0] word
);
    always_comb begin
        case (addr)
            4'd0:    word = cfg_word(8'h1E, 8'h00);
            4'd1:    word = cfg_word(8'h00, 8'h17);
            4'd2:    word = cfg_word(8'h02, 8'h17);
            4'd3:    word = cfg_word(8'h04, 8'h79);
            4'd4:    word = cfg_word(8'h06, 8'h79);
            4'd5:    word = cfg_word(8'h08, 8'h12);
            4'd6:    word = cfg_word(8'h0A, 8'h00);
            4'd7:    word = cfg_word(8'h0C, 8'h00);
            4'd8:    word = cfg_word(8'h0E, 8'h42);
            4'd9:    word = cfg_word(8'h12, 8'h01);
            default: word = '0;
        endcase
    end
endmodule

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks the codec ROM through the I2C controller with per-word retry and timeout
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int NUM_WORDS      = 10,
    parameter int POWER_WAIT_CYC = 2000,
    parameter int GAP_CYC        = 20,
    parameter int TIMEOUT_CYC    = 200,
    parameter int MAX_RETRY      = 3
) (
    input logic clk_200khz,
    input logic reset_ctrl,
    i2c_config_sequencer_if.master bus
);
    localparam int PW_W = $clog2(POWER_WAIT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(POWER_WAIT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    state_t state;
    logic [PW_W-1:0] pw_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [1:0] retry;
    logic word_ok;
    logic ack;
    logic [WORD_W-1:0] rom_word;
    i2c_config_rom u_rom (.addr(bus.word_index), .word(rom_word));
    assign ack = bus.end_in & ~bus.error_in;
    always_ff @(posedge clk_200khz or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            state <= POWER_WAIT;
            pw_cnt <= '0;
            gap_cnt <= '0;
            to_cnt <= '0;
            retry <= '0;
            word_ok <= 1'b0;
            bus.config_data <= '0;
            bus.start_bit <= 1'b0;
            bus.stop_bit <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.fail <= 1'b0;
            bus.word_index <= '0;
        end else begin
            bus.start_bit <= 1'b0;
            case (state)
                POWER_WAIT: begin
                    bus.busy <= 1'b1;
                    pw_cnt <= (pw_cnt == PW_LAST) ? '0 : pw_cnt + 1'b1;
                    state <= (pw_cnt == PW_LAST) ? LOAD : POWER_WAIT;
                end
                IDLE, DONE, FAIL: begin
                    if (bus.go) begin
                        bus.done <= 1'b0;
                        bus.fail <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.word_index <= '0;
                        retry <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bus.config_data <= rom_word;
                    to_cnt <= '0;
                    state <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (bus.ready_in) begin
                        bus.start_bit <= 1'b1;
                        bus.stop_bit <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT_END;
                WAIT_END: begin
                    to_cnt <= to_cnt + 1'b1;
                    // END wins over a coincident timeout because ack/NACK is decided from END first
                    if (bus.end_in || to_cnt == TO_LAST) begin
                        bus.stop_bit <= 1'b0;
                        word_ok <= ack;
                        retry <= ack ? '0 : retry + 1'b1;
                        if (!ack && retry + 2'd1 == RETRY_LIMIT) begin
                            bus.fail <= 1'b1;
                            bus.busy <= 1'b0;
                            state <= FAIL;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
                    state <= (gap_cnt == GAP_LAST) ? NEXT : GAP;
                end
                NEXT: begin
                    if (word_ok && bus.word_index == LAST_IDX) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state <= DONE;
                    end else begin
                        bus.word_index <= word_ok ? bus.word_index + 1'b1 : bus.word_index;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: scoreboard bench with a behavioural controller responder
module tb_i2c_config_sequencer;
    localparam int NUM_WORDS = 10;
    localparam int POWER_WAIT_CYC = 2000;
    localparam int GAP_CYC = 20;
    localparam int TIMEOUT_CYC = 200;
    localparam int MAX_RETRY = 3;
    localparam int RESP_DLY = 30;
    typedef struct packed {
        logic [23:0] data;
        logic [3:0] idx;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    i2c_config_sequencer_if bus();
    i2c_config_sequencer #(
        .NUM_WORDS(NUM_WORDS), .POWER_WAIT_CYC(POWER_WAIT_CYC), .GAP_CYC(GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_200khz(clk),
        .reset_ctrl(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [23:0] rom_exp [16];
    int n_checks = 0;
    int n_fail = 0;
    int silent_word = -1;
    int nack_word = -1;
    int nack_times = 0;
    int att [16];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.data = rom_exp[i];
            e.idx = 4'(i);
            exp_q.push_back(e);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.go = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {bus.config_data, bus.start_bit, bus.stop_bit, bus.busy,
                            bus.done, bus.fail, bus.word_index}, 64'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask
    task automatic wait_start(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.start_bit) begin
                cycles = i;
                break;
            end
        end
    endtask
    task automatic wait_term(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done || bus.fail) begin
                ok = 1'b1;
                break;
            end
        end
        chk("terminal_reached", ok, 1);
    endtask
    task automatic wait_queue(input int size, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == size) begin
                ok = 1'b1;
                break;
            end
        end
        chk("queue_progress", ok, 1);
    endtask
    // Controller model: END a fixed delay after each START, NACK/silence per scenario knobs
    initial begin
        int cd;
        bit nack;
        cd = -1;
        nack = 1'b0;
        bus.end_in = 1'b0;
        bus.error_in = 1'b0;
        forever begin
            @(negedge clk);
            bus.end_in = 1'b0;
            bus.error_in = 1'b0;
            if (rst) begin
                cd = -1;
                foreach (att[i]) att[i] = 0;
            end else if (bus.start_bit) begin
                att[bus.word_index] = att[bus.word_index] + 1;
                nack = int'(bus.word_index) == nack_word && att[bus.word_index] <= nack_times;
                cd = (int'(bus.word_index) == silent_word) ? -1 : RESP_DLY;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    bus.end_in = 1'b1;
                    bus.error_in = nack;
                    cd = -1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && bus.start_bit) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", bus.start_bit, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("start_data", bus.config_data, mon_e.data);
                chk("start_index", bus.word_index, mon_e.idx);
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
    initial begin
        int c;
        int bad;
        rom_exp = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                    24'h340A00, 24'h340C00, 24'h340E42, 24'h341201, 24'h0, 24'h0,
                    24'h0, 24'h0, 24'h0, 24'h0};
        bus.go = 1'b0;
        bus.ready_in = 1'b1;
        // clean run
        do_reset();
        push_range(0, 9);
        wait_start(POWER_WAIT_CYC + 100, c);
        chk("power_up_latency", c, POWER_WAIT_CYC + 2);
        wait_start(200, c);
        chk("word_spacing", c, RESP_DLY + GAP_CYC + 4);
        wait_term(5000);
        chk("s1_done", bus.done, 1);
        chk("s1_busy", bus.busy, 0);
        chk("s1_fail", bus.fail, 0);
        chk("s1_index", bus.word_index, NUM_WORDS - 1);
        chk("s1_drained", exp_q.size(), 0);
        // single NACK on word 3
        nack_word = 3;
        nack_times = 1;
        do_reset();
        push_range(0, 3);
        push_range(3, 9);
        wait_term(POWER_WAIT_CYC + 5000);
        chk("s2_done", bus.done, 1);
        chk("s2_fail", bus.fail, 0);
        chk("s2_drained", exp_q.size(), 0);
        // persistent NACK on word 5
        nack_word = 5;
        nack_times = MAX_RETRY;
        do_reset();
        push_range(0, 5);
        push_range(5, 5);
        push_range(5, 5);
        wait_term(POWER_WAIT_CYC + 5000);
        repeat (300) @(negedge clk);
        chk("s3_fail", bus.fail, 1);
        chk("s3_done", bus.done, 0);
        chk("s3_busy", bus.busy, 0);
        chk("s3_index", bus.word_index, 5);
        chk("s3_stop", bus.stop_bit, 0);
        chk("s3_drained", exp_q.size(), 0);
        // controller never answers word 0
        nack_word = -1;
        silent_word = 0;
        do_reset();
        push_range(0, 0);
        push_range(0, 0);
        push_range(0, 0);
        wait_start(POWER_WAIT_CYC + 100, c);
        chk("s4_first_start", c, POWER_WAIT_CYC + 2);
        c = 0;
        for (int i = 0; i < 400 && bus.stop_bit; i++) begin
            c++;
            @(negedge clk);
        end
        chk("s4_stop_width", c, TIMEOUT_CYC + 1);
        wait_term(2000);
        chk("s4_fail", bus.fail, 1);
        chk("s4_index", bus.word_index, 0);
        chk("s4_drained", exp_q.size(), 0);
        // READY held low after LOAD, then GO while busy, GO after DONE, async reset
        silent_word = -1;
        bus.ready_in = 1'b0;
        do_reset();
        push_range(0, 9);
        c = 0;
        bad = 0;
        for (int i = 1; i <= POWER_WAIT_CYC + 500; i++) begin
            @(negedge clk);
            if (bus.start_bit) c++;
            if (i > POWER_WAIT_CYC && bus.config_data !== rom_exp[0]) bad++;
        end
        chk("ready_low_no_start", c, 0);
        chk("ready_low_data_stable", bad, 0);
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("start_after_ready", bus.start_bit, 1);
        wait_queue(5, 2000);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("go_busy_index", bus.word_index, 4);
        chk("go_busy_busy", bus.busy, 1);
        wait_term(5000);
        chk("s5_done", bus.done, 1);
        chk("s5_drained", exp_q.size(), 0);
        push_range(0, 9);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("go_done_clears", bus.done, 0);
        chk("go_index", bus.word_index, 0);
        chk("go_busy", bus.busy, 1);
        wait_start(10, c);
        chk("go_start_latency", c, 2);
        wait_queue(7, 2000);
        repeat (5) @(posedge clk);
        #3;
        chk("pre_reset_stop", bus.stop_bit, 1);
        rst = 1'b1;
        #1;
        chk("async_reset", {bus.config_data, bus.start_bit, bus.stop_bit, bus.busy,
                            bus.done, bus.fail, bus.word_index}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Upstream stage of i2c_controller. After power-up or on GO, it walks a fixed table of 24-bit codec configuration words and presents them one at a time on CONFIG_DATA.
- For each word it issues START_BIT/STOP_BIT and waits for END. It retries words that were NACKed or timed out, then reports DONE or FAIL to top level.
- Word format: [23:17] device address, [16] R/W (always 0), [15:8] register address, [7:0] data.

Parameters:
- NUM_WORDS, 10, number of table entries sent (1..16).
- POWER_WAIT_CYC, 2000, settle delay before the first word (10 ms at 200 kHz).
- GAP_CYC, 20, idle cycles between consecutive words.
- TIMEOUT_CYC, 200, maximum cycles from launch to END before the attempt counts as failed.
- MAX_RETRY, 3, attempts allowed per word, including the first.

Ports:
- CLK_200KHZ  in  1  reference clock, rising edge.
- RESET_CTRL  in  1  asynchronous active-high reset.
- GO  in  1  single-cycle pulse; restarts the sequence from word 0. Ignored while BUSY.
- READY_IN  in  1  controller READY; high means the controller is idle and can accept a word.
- END_IN  in  1  controller END; a high cycle marks completion of the current transfer.
- ERROR_IN  in  1  controller ERROR_LED; high when sampled with END_IN means NACK.
- CONFIG_DATA  out  24  word currently presented to the controller.
- START_BIT  out  1  single-cycle launch pulse.
- STOP_BIT  out  1  high from launch until END_IN or timeout.
- BUSY  out  1  high in every state except IDLE, DONE and FAIL.
- DONE  out  1  sticky; set when all words are acknowledged.
- FAIL  out  1  sticky; set when any word exhausts MAX_RETRY.
- WORD_INDEX  out  4  index of the current word, or of the failing word once FAIL is set.

Behaviour:
- Reset values: CONFIG_DATA=0, START_BIT=0, STOP_BIT=0, BUSY=0, DONE=0, FAIL=0, WORD_INDEX=0. State=POWER_WAIT with all counters cleared, so the sequence self-starts after reset release.
- All outputs are registered. CONFIG_DATA changes only in LOAD and stays stable from LOAD through WAIT_END.
- POWER_WAIT: count POWER_WAIT_CYC cycles, then go to LOAD.
- LOAD: CONFIG_DATA <= rom[WORD_INDEX]; clear the timeout counter; next state WAIT_READY.
- WAIT_READY: stay until READY_IN=1, then go to LAUNCH.
- LAUNCH: START_BIT=1 for exactly one cycle; STOP_BIT<=1; next state WAIT_END.
- WAIT_END: increment the timeout counter each cycle.
  - END_IN=1 and ERROR_IN=0: success. STOP_BIT<=0, clear the retry count, go to GAP.
  - END_IN=1 and ERROR_IN=1, or the timeout counter reaches TIMEOUT_CYC-1: failed attempt. STOP_BIT<=0, increment the retry count.
  - After a failed attempt: if retry count == MAX_RETRY, go to FAIL; otherwise go to GAP with the same WORD_INDEX.
  - END_IN arriving on the same cycle as the timeout is treated as END, not timeout.
- GAP: count GAP_CYC cycles, then go to NEXT.
- NEXT: on success, increment WORD_INDEX. If the result equals NUM_WORDS, go to DONE and leave WORD_INDEX at NUM_WORDS-1. Otherwise go to LOAD. On retry, go straight to LOAD.
- DONE and FAIL: terminal states.
  - Set the sticky flag; BUSY=0.
  - GO clears DONE, FAIL, WORD_INDEX and the retry count, then goes to LOAD (no power wait).
  - In IDLE, GO also goes to LOAD.
- GO while BUSY: ignored, with no side effects.
- Reset mid-transfer: asynchronous return to reset values. STOP_BIT drops immediately; the controller is reset by the same RESET_CTRL.
- Counters are sized to their parameters with no wrap.
  - WORD_INDEX never exceeds NUM_WORDS-1.
  - The retry counter is 2 bits, which is sufficient for MAX_RETRY<=3; MAX_RETRY must not exceed 3 unless the counter is widened.
- Latency: LOAD to START_BIT is 2 cycles when READY_IN is already high.

Decomposition:
- Package i2c_cfg_pkg holds:
  - state encodings (POWER_WAIT, IDLE, LOAD, WAIT_READY, LAUNCH, WAIT_END, GAP, NEXT, DONE, FAIL);
  - codec device address constant 7'h1A;
  - word-format field positions.
- Sub-module i2c_config_rom: combinational case lookup, 4-bit address to 24-bit word, with 0 returned for unused addresses.
- The sequencer instantiates the ROM and holds the FSM, the counters and the output registers.

Test Plan:
- Reset release, READY_IN=1, END_IN returned 30 cycles after each START, ERROR_IN=0 -> first START_BIT exactly POWER_WAIT_CYC+2 cycles after release. Then 10 START pulses with CONFIG_DATA = rom[0..9], spaced by GAP_CYC+overhead, and DONE=1 with BUSY=0.
- ERROR_IN=1 at END on word 3 for the first attempt only -> word 3 presented twice with identical CONFIG_DATA, then the sequence completes with DONE=1.
- ERROR_IN=1 on every attempt of word 5 -> exactly 3 START pulses for word 5, FAIL=1, WORD_INDEX=5, no further STARTs.
- END_IN never returned for word 0 -> STOP_BIT drops after 200 cycles, the word is retried, and FAIL=1 after the third timeout.
- READY_IN held low 500 cycles after LOAD -> no START_BIT and CONFIG_DATA stable; START occurs 1 cycle after READY_IN rises.
- GO pulsed while BUSY -> ignored. GO after DONE -> DONE clears, WORD_INDEX=0, first START within 2 cycles with no power wait. Async reset asserted mid-WAIT_END -> all outputs return to their reset values without waiting for a clock edge.
